// File: rtl/panic_mat_cfg_sched_pkg.sv
// rtl/panic_mat_cfg_sched_pkg.sv - shared state encodings, default widths and helpers for the MAT config scheduler
package panic_mat_cfg_sched_pkg;

  typedef enum logic [1:0] {
    MAT_CFG_STATE_IDLE  = 2'd0,
    MAT_CFG_STATE_WRITE = 2'd1,
    MAT_CFG_STATE_GAP   = 2'd2
  } mat_cfg_state_e;

  localparam int DEF_KEY_WIDTH   = 16;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_VALUE_WIDTH = 128;

  localparam int GAP_CNT_WIDTH = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/panic_rr_arbiter.sv
// rtl/panic_rr_arbiter.sv - combinational round-robin arbiter: first request at or after ptr, cyclically
module panic_rr_arbiter
  import panic_mat_cfg_sched_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o,
  output logic               valid_o
);

  always_comb begin
    int c;
    logic [IW-1:0] ci;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    c       = 0;
    ci      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = int'(ptr_i) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      ci = IW'(c);
      if (en_i && !valid_o && req_i[ci]) begin
        valid_o     = 1'b1;
        grant_o[ci] = 1'b1;
        idx_o       = ci;
      end
    end
  end

endmodule

// File: rtl/panic_mat_cfg_sched.sv
// rtl/panic_mat_cfg_sched.sv - round-robin scheduler serialising config sources onto the single MAT write port
// Optional per-requester / hold-stall statistics under PANIC_MAT_CFG_STATS_EN.
module panic_mat_cfg_sched
  import panic_mat_cfg_sched_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  KEY_WIDTH   = DEF_KEY_WIDTH,
  parameter int  VALUE_WIDTH = DEF_VALUE_WIDTH,
  parameter int  ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int  GAP_CYCLES  = 1,
  parameter int  CNT_WIDTH   = 16,
  localparam int IW          = idx_width(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             s_req_valid,
  output logic [NUM_REQ-1:0]             s_req_ready,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   s_req_key,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0] s_req_value,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  s_req_addr,
  input  logic                           cfg_hold,
  output logic                           config_mat_en,
  output logic [KEY_WIDTH-1:0]           config_mat_key,
  output logic [VALUE_WIDTH-1:0]         config_mat_value,
  output logic [ADDR_WIDTH-1:0]          config_mat_addr,
  output logic                           busy,
  output logic [IW-1:0]                  last_grant,
`ifdef PANIC_MAT_CFG_STATS_EN
  output logic [NUM_REQ*CNT_WIDTH-1:0]   req_wr_count,
  output logic [CNT_WIDTH-1:0]           hold_stall_count,
`endif
  output logic [CNT_WIDTH-1:0]           wr_count
);

  localparam logic [GAP_CNT_WIDTH-1:0] GAP_LOAD =
    GAP_CNT_WIDTH'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  mat_cfg_state_e           state_q, state_d;
  logic [GAP_CNT_WIDTH-1:0] gap_q, gap_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [KEY_WIDTH-1:0]     key_q;
  logic [VALUE_WIDTH-1:0]   value_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [IW-1:0]            last_grant_q;
  logic [CNT_WIDTH-1:0]     wr_cnt_q;

  logic [NUM_REQ-1:0]       grant;
  logic [IW-1:0]            sel;
  logic                     accept;
  logic                     arb_en;

  // Gating with rst keeps ready low while reset is held, even with valids pending.
  assign arb_en = rst && (state_q == MAT_CFG_STATE_IDLE) && !cfg_hold;

  panic_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (s_req_valid),
    .ptr_i   (ptr_q),
    .en_i    (arb_en),
    .grant_o (grant),
    .idx_o   (sel),
    .valid_o (accept)
  );

  assign ptr_d = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MAT_CFG_STATE_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      MAT_CFG_STATE_IDLE: begin
        if (accept) state_d = MAT_CFG_STATE_WRITE;
      end
      MAT_CFG_STATE_WRITE: begin
        if (GAP_CYCLES > 0) begin
          state_d = MAT_CFG_STATE_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = MAT_CFG_STATE_IDLE;
        end
      end
      MAT_CFG_STATE_GAP: begin
        if (gap_q == '0) state_d = MAT_CFG_STATE_IDLE;
        else             gap_d   = gap_q - GAP_CNT_WIDTH'(1);
      end
      default: state_d = MAT_CFG_STATE_IDLE;
    endcase
  end

  always_comb begin
    s_req_ready   = grant;
    config_mat_en = (state_q == MAT_CFG_STATE_WRITE);
    busy          = (state_q != MAT_CFG_STATE_IDLE);
  end

  // Payload is captured only at acceptance, so it stays frozen through WRITE and GAP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q        <= '0;
      key_q        <= '0;
      value_q      <= '0;
      addr_q       <= '0;
      last_grant_q <= '0;
      wr_cnt_q     <= '0;
    end else begin
      if (accept) begin
        ptr_q        <= ptr_d;
        key_q        <= s_req_key[sel*KEY_WIDTH +: KEY_WIDTH];
        value_q      <= s_req_value[sel*VALUE_WIDTH +: VALUE_WIDTH];
        addr_q       <= s_req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
        last_grant_q <= sel;
      end
      if (state_q == MAT_CFG_STATE_WRITE) wr_cnt_q <= wr_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign config_mat_key   = key_q;
  assign config_mat_value = value_q;
  assign config_mat_addr  = addr_q;
  assign last_grant       = last_grant_q;
  assign wr_count         = wr_cnt_q;

`ifdef PANIC_MAT_CFG_STATS_EN
  logic [NUM_REQ*CNT_WIDTH-1:0] req_cnt_q;
  logic [CNT_WIDTH-1:0]         hold_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_cnt_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      if (state_q == MAT_CFG_STATE_WRITE)
        req_cnt_q[last_grant_q*CNT_WIDTH +: CNT_WIDTH] <=
          req_cnt_q[last_grant_q*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
      if ((state_q == MAT_CFG_STATE_IDLE) && cfg_hold && (|s_req_valid))
        hold_cnt_q <= hold_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign req_wr_count     = req_cnt_q;
  assign hold_stall_count = hold_cnt_q;
`endif

endmodule

// File: tb/tb_panic_mat_cfg_sched.sv
// tb/tb_panic_mat_cfg_sched.sv - directed self-checking bench for panic_mat_cfg_sched
module tb_panic_mat_cfg_sched;

  logic         clk;
  logic         rst;
  logic [3:0]   valid;
  logic [63:0]  key;
  logic [511:0] value;
  logic [31:0]  addr;
  logic         hold;

  logic [3:0]   ready_a, ready_b, ready_c;
  logic         en_a, en_b, en_c;
  logic [15:0]  key_a, key_b, key_c;
  logic [127:0] val_a, val_b, val_c;
  logic [7:0]   addr_a, addr_b, addr_c;
  logic         busy_a, busy_b, busy_c;
  logic [1:0]   lg_a, lg_b, lg_c;
  logic [15:0]  wc_a, wc_b;
  logic [3:0]   wc_c;
`ifdef PANIC_MAT_CFG_STATS_EN
  logic [63:0]  rwc_a, rwc_b;
  logic [15:0]  hsc_a, hsc_b;
  logic [15:0]  rwc_c;
  logic [3:0]   hsc_c;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  panic_mat_cfg_sched #(.GAP_CYCLES(1), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .s_req_valid(valid), .s_req_ready(ready_a),
    .s_req_key(key), .s_req_value(value), .s_req_addr(addr), .cfg_hold(hold),
    .config_mat_en(en_a), .config_mat_key(key_a), .config_mat_value(val_a),
    .config_mat_addr(addr_a), .busy(busy_a), .last_grant(lg_a),
`ifdef PANIC_MAT_CFG_STATS_EN
    .req_wr_count(rwc_a), .hold_stall_count(hsc_a),
`endif
    .wr_count(wc_a)
  );

  panic_mat_cfg_sched #(.GAP_CYCLES(0), .CNT_WIDTH(16)) u_g0 (
    .clk(clk), .rst(rst), .s_req_valid(valid), .s_req_ready(ready_b),
    .s_req_key(key), .s_req_value(value), .s_req_addr(addr), .cfg_hold(hold),
    .config_mat_en(en_b), .config_mat_key(key_b), .config_mat_value(val_b),
    .config_mat_addr(addr_b), .busy(busy_b), .last_grant(lg_b),
`ifdef PANIC_MAT_CFG_STATS_EN
    .req_wr_count(rwc_b), .hold_stall_count(hsc_b),
`endif
    .wr_count(wc_b)
  );

  panic_mat_cfg_sched #(.GAP_CYCLES(1), .CNT_WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .s_req_valid(valid), .s_req_ready(ready_c),
    .s_req_key(key), .s_req_value(value), .s_req_addr(addr), .cfg_hold(hold),
    .config_mat_en(en_c), .config_mat_key(key_c), .config_mat_value(val_c),
    .config_mat_addr(addr_c), .busy(busy_c), .last_grant(lg_c),
`ifdef PANIC_MAT_CFG_STATS_EN
    .req_wr_count(rwc_c), .hold_stall_count(hsc_c),
`endif
    .wr_count(wc_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    valid = '0;
    hold  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    valid = 4'hF;
    key   = {16'd4, 16'd3, 16'd2, 16'd1};
    sample();
    n_checks++; if (ready_a !== 4'b0000) $display("FAIL reset_ready got %b exp 0000", ready_a); else n_pass++;
    n_checks++; if (en_a !== 1'b0) $display("FAIL reset_en got %b exp 0", en_a); else n_pass++;
    n_checks++; if (key_a !== 16'd0) $display("FAIL reset_key got %0h exp 0", key_a); else n_pass++;
    n_checks++; if (val_a !== 128'd0) $display("FAIL reset_value got %0h exp 0", val_a); else n_pass++;
    n_checks++; if (addr_a !== 8'd0) $display("FAIL reset_addr got %0h exp 0", addr_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_a); else n_pass++;
    n_checks++; if (lg_a !== 2'd0) $display("FAIL reset_last_grant got %0d exp 0", lg_a); else n_pass++;
    n_checks++; if (wc_a !== 16'd0) $display("FAIL reset_wr_count got %0d exp 0", wc_a); else n_pass++;
    valid = '0;
  endtask

  task automatic test_write_timing();
    do_reset();
    key   = '0;
    value = '0;
    addr  = '0;
    key[15:0]    = 16'd33;
    value[127:0] = 128'h400;
    valid = 4'b0001;
    sample();
    n_checks++; if (ready_a !== 4'b0001) $display("FAIL wt_ready_T got %b exp 0001", ready_a); else n_pass++;
    n_checks++; if (en_a !== 1'b0) $display("FAIL wt_en_T got %b exp 0", en_a); else n_pass++;
    next_cycle();
    valid = '0;
    sample();
    n_checks++; if (en_a !== 1'b1) $display("FAIL wt_en_T1 got %b exp 1", en_a); else n_pass++;
    n_checks++; if (key_a !== 16'd33) $display("FAIL wt_key got %0d exp 33", key_a); else n_pass++;
    n_checks++; if (val_a !== 128'h400) $display("FAIL wt_value got %0h exp 400", val_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b1) $display("FAIL wt_busy_T1 got %b exp 1", busy_a); else n_pass++;
    n_checks++; if (ready_a !== 4'b0000) $display("FAIL wt_ready_T1 got %b exp 0000", ready_a); else n_pass++;
    next_cycle();
    sample();
    n_checks++; if (en_a !== 1'b0) $display("FAIL wt_en_T2 got %b exp 0", en_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b1) $display("FAIL wt_busy_gap got %b exp 1", busy_a); else n_pass++;
    n_checks++; if (wc_a !== 16'd1) $display("FAIL wt_wr_count got %0d exp 1", wc_a); else n_pass++;
    n_checks++; if (key_a !== 16'd33) $display("FAIL wt_key_hold got %0d exp 33", key_a); else n_pass++;
    next_cycle();
    sample();
    n_checks++; if (busy_a !== 1'b0) $display("FAIL wt_busy_idle got %b exp 0", busy_a); else n_pass++;
  endtask

  task automatic test_rotation();
    do_reset();
    key   = {16'd13, 16'd12, 16'd11, 16'd10};
    valid = 4'hF;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) next_cycle();
      sample();
      n_checks++;
      if (en_a !== (c % 3 == 1)) $display("FAIL rot_en c=%0d got %b exp %b", c, en_a, (c % 3 == 1));
      else n_pass++;
      if (c % 3 == 0) begin
        n_checks++;
        if (ready_a !== 4'(1 << ((c / 3) % 4))) $display("FAIL rot_ready c=%0d got %b exp %b", c, ready_a, 4'(1 << ((c / 3) % 4)));
        else n_pass++;
      end
      if (c % 3 == 1) begin
        n_checks++;
        if (key_a !== 16'(10 + (c / 3) % 4)) $display("FAIL rot_key c=%0d got %0d exp %0d", c, key_a, 10 + (c / 3) % 4);
        else n_pass++;
        n_checks++;
        if (lg_a !== 2'((c / 3) % 4)) $display("FAIL rot_last_grant c=%0d got %0d exp %0d", c, lg_a, (c / 3) % 4);
        else n_pass++;
      end
    end
    valid = '0;
  endtask

  task automatic test_hold();
    do_reset();
    key   = {16'd0, 16'h2222, 16'd0, 16'd0};
    hold  = 1'b1;
    valid = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) next_cycle();
      sample();
      n_checks++; if (ready_a !== 4'b0000) $display("FAIL hold_ready c=%0d got %b exp 0000", c, ready_a); else n_pass++;
      n_checks++; if (en_a !== 1'b0) $display("FAIL hold_en c=%0d got %b exp 0", c, en_a); else n_pass++;
    end
    next_cycle();
    hold = 1'b0;
    sample();
    n_checks++; if (ready_a !== 4'b0100) $display("FAIL hold_release_ready got %b exp 0100", ready_a); else n_pass++;
`ifdef PANIC_MAT_CFG_STATS_EN
    n_checks++; if (hsc_a !== 16'd20) $display("FAIL hold_stall_count got %0d exp 20", hsc_a); else n_pass++;
`endif
    next_cycle();
    valid = '0;
    sample();
    n_checks++; if (en_a !== 1'b1) $display("FAIL hold_write_en got %b exp 1", en_a); else n_pass++;
    n_checks++; if (key_a !== 16'h2222) $display("FAIL hold_write_key got %0h exp 2222", key_a); else n_pass++;
    n_checks++; if (lg_a !== 2'd2) $display("FAIL hold_last_grant got %0d exp 2", lg_a); else n_pass++;
    next_cycle();
    sample();
`ifdef PANIC_MAT_CFG_STATS_EN
    n_checks++; if (rwc_a[47:32] !== 16'd1) $display("FAIL req2_wr_count got %0d exp 1", rwc_a[47:32]); else n_pass++;
    n_checks++; if (rwc_a[15:0] !== 16'd0) $display("FAIL req0_wr_count got %0d exp 0", rwc_a[15:0]); else n_pass++;
`endif
    n_checks++; if (wc_a !== 16'd1) $display("FAIL hold_wr_count got %0d exp 1", wc_a); else n_pass++;
  endtask

  task automatic test_gap_zero();
    int n_en;
    do_reset();
    key   = {16'd0, 16'd0, 16'd0, 16'h0077};
    valid = 4'b0001;
    n_en  = 0;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) next_cycle();
      sample();
      if (c < 10) begin
        n_checks++;
        if (en_b !== (c % 2 == 1)) $display("FAIL gap0_en c=%0d got %b exp %b", c, en_b, (c % 2 == 1));
        else n_pass++;
      end
      if (en_b === 1'b1) n_en++;
    end
    next_cycle();
    sample();
    n_checks++; if (n_en !== 100) $display("FAIL gap0_pulses got %0d exp 100", n_en); else n_pass++;
    n_checks++; if (wc_b !== 16'd100) $display("FAIL gap0_wr_count got %0d exp 100", wc_b); else n_pass++;
    n_checks++; if (key_b !== 16'h0077) $display("FAIL gap0_key got %0h exp 77", key_b); else n_pass++;
    valid = '0;
  endtask

  task automatic test_counter_wrap();
    int n_en;
    do_reset();
    valid = 4'b0001;
    n_en  = 0;
    for (int c = 0; c <= 50; c++) begin
      if (c > 0) next_cycle();
      sample();
      if (en_c === 1'b1) n_en++;
    end
    n_checks++; if (n_en !== 17) $display("FAIL wrap_pulses got %0d exp 17", n_en); else n_pass++;
    n_checks++; if (wc_c !== 4'd1) $display("FAIL wrap_wr_count got %0d exp 1", wc_c); else n_pass++;
    n_checks++; if (wc_a !== 16'd17) $display("FAIL wrap_wide_wr_count got %0d exp 17", wc_a); else n_pass++;
    valid = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    key   = {16'd0, 16'd0, 16'h0055, 16'd0};
    valid = 4'b0010;
    sample();
    n_checks++; if (ready_a !== 4'b0010) $display("FAIL ar_ready got %b exp 0010", ready_a); else n_pass++;
    next_cycle();
    #1;
    n_checks++; if (en_a !== 1'b1) $display("FAIL ar_en_before got %b exp 1", en_a); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (en_a !== 1'b0) $display("FAIL ar_en_after got %b exp 0", en_a); else n_pass++;
    n_checks++; if (wc_a !== 16'd0) $display("FAIL ar_wr_count got %0d exp 0", wc_a); else n_pass++;
    n_checks++; if (lg_a !== 2'd0) $display("FAIL ar_last_grant got %0d exp 0", lg_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL ar_busy got %b exp 0", busy_a); else n_pass++;
    next_cycle();
    rst = 1'b1;
    sample();
    n_checks++; if (ready_a !== 4'b0010) $display("FAIL ar_rereq_ready got %b exp 0010", ready_a); else n_pass++;
    next_cycle();
    valid = '0;
    sample();
    n_checks++; if (en_a !== 1'b1) $display("FAIL ar_rewrite_en got %b exp 1", en_a); else n_pass++;
    n_checks++; if (key_a !== 16'h0055) $display("FAIL ar_rewrite_key got %0h exp 55", key_a); else n_pass++;
    next_cycle();
    sample();
    n_checks++; if (wc_a !== 16'd1) $display("FAIL ar_rewrite_count got %0d exp 1", wc_a); else n_pass++;
  endtask

  initial begin
    rst   = 1'b0;
    valid = '0;
    key   = '0;
    value = '0;
    addr  = '0;
    hold  = 1'b0;
    test_reset();
    test_write_timing();
    test_rotation();
    test_hold();
    test_gap_zero();
    test_counter_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
